cmd_stream_bridge: RTL

Byte-stream front end that drives the arena command port of `top` as its initiator. It collects 5-byte command frames from a host byte stream (UART/USB FIFO side) and issues each as a single `cmd`/`cmd_arg0` transaction. It waits for `top` to complete and returns status plus the 32-bit `cmd_res` as a byte stream. It replaces the bench-only command driver, so the simulator runs from a host link.

---
 rtl/cmd_stream_bridge_pkg.sv | 34 +++
 rtl/cmd_stream_bridge_cmd_res_serializer.sv | 46 ++++
 rtl/cmd_stream_bridge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cmd_stream_bridge_pkg.sv
// Shared command/response codes and bridge state encodings for the host
// byte-stream front end of the arena command port.
package cmd_stream_bridge_pkg;

   typedef logic [2:0] opcode_t;

   // Command opcodes understood by top
   localparam opcode_t CMD_NOP        = 3'd0;
   localparam opcode_t CMD_SEED       = 3'd1;
   localparam opcode_t CMD_ADVANCE    = 3'd2;
   localparam opcode_t CMD_READ_CELL  = 3'd3;
   localparam opcode_t CMD_WRITE_CELL = 3'd4;

   // Response status bytes returned to the host
   localparam logic [7:0] RSP_OK      = 8'h00;
   localparam logic [7:0] RSP_BAD_HDR = 8'hE1;
   localparam logic [7:0] RSP_TIMEOUT = 8'hE2;

   // Bridge FSM state encodings
   localparam logic [2:0] ST_RX_HDR    = 3'd0;
   localparam logic [2:0] ST_RX_ARG    = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_TX_STATUS = 3'd5;
   localparam logic [2:0] ST_TX_RES    = 3'd6;
   localparam logic [2:0] ST_TX_ERR    = 3'd7;

   // A header is well formed when its reserved upper bits are all zero
   function automatic logic hdr_ok(input logic [7:0] hdr);
      return (hdr[7:3] == 5'd0);
   endfunction

endpackage

// File: rtl/cmd_stream_bridge_cmd_res_serializer.sv
// Response serializer: loads a status byte plus optional 32-bit result and
// presents them MSB first, one byte per host handshake. tx_data is a
// register, so it never depends combinationally on tx_ready.
module cmd_res_serializer
   import cmd_stream_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        load_single,
   input  logic [7:0]  load_status,
   input  logic [31:0] load_res,
   input  logic        advance,
   output logic [7:0]  tx_data,
   output logic        last
);

   logic [7:0]  tx_data_r;
   logic [31:0] shift_r;
   logic [2:0]  remain_r;

   // Load a new response or step to the next byte after each transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_data_r <= 8'h00;
         shift_r   <= 32'h0000_0000;
         remain_r  <= 3'd0;
      end else if (load) begin
         tx_data_r <= load_status;
         shift_r   <= load_single ? 32'h0000_0000 : load_res;
         remain_r  <= load_single ? 3'd0 : 3'd4;
      end else if (advance) begin
         tx_data_r <= shift_r[31:24];
         shift_r   <= {shift_r[23:0], 8'h00};
         remain_r  <= (remain_r != 3'd0) ? (remain_r - 3'd1) : 3'd0;
      end else begin
         tx_data_r <= tx_data_r;
         shift_r   <= shift_r;
         remain_r  <= remain_r;
      end
   end

   assign tx_data = tx_data_r;
   assign last    = (remain_r == 3'd0);

endmodule

// File: rtl/cmd_stream_bridge.sv
// Host byte-stream bridge: collects 5-byte command frames, issues them to
// top as a single cmd/cmd_arg0 strobe, waits for completion and streams the
// status plus 32-bit result back to the host.
module cmd_stream_bridge
   import cmd_stream_bridge_pkg::*;
#(
   parameter int RX_TIMEOUT    = 1000000,
   parameter int TIMEOUT_WIDTH = 20
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [2:0]  cmd,
   output logic [31:0] cmd_arg0,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   input  logic [31:0] cmd_res,
   output logic        busy
);

   logic [2:0]               state_r;
   logic [2:0]               state_nxt_s;
   logic [2:0]               cmd_r;
   logic [31:0]              arg_r;
   logic [1:0]               byte_idx_r;
   logic [TIMEOUT_WIDTH-1:0] to_cnt_r;
   logic                     rx_fire_s;
   logic                     tx_fire_s;
   logic                     timeout_hit_s;
   logic                     ser_load_s;
   logic                     ser_single_s;
   logic [7:0]               ser_status_s;
   logic                     ser_last_s;

   assign rx_ready      = ((state_r == ST_RX_HDR) || (state_r == ST_RX_ARG)) && !reset;
   assign tx_valid      = (state_r == ST_TX_STATUS) || (state_r == ST_TX_RES) ||
                          (state_r == ST_TX_ERR);
   assign busy          = (state_r == ST_ISSUE) || (state_r == ST_WAIT_LOW) ||
                          (state_r == ST_WAIT_DONE);
   assign cmd_valid     = (state_r == ST_ISSUE) && cmd_ready;
   assign rx_fire_s     = rx_valid && rx_ready;
   assign tx_fire_s     = tx_valid && tx_ready;
   assign timeout_hit_s = (to_cnt_r == TIMEOUT_WIDTH'(RX_TIMEOUT - 1));
   assign cmd           = cmd_r;
   assign cmd_arg0      = arg_r;

   // Next-state decode and serializer load requests
   always_comb begin
      state_nxt_s  = state_r;
      ser_load_s   = 1'b0;
      ser_single_s = 1'b0;
      ser_status_s = RSP_OK;
      case (state_r)
         ST_RX_HDR: begin
            if (rx_fire_s) begin
               if (hdr_ok(rx_data)) begin
                  state_nxt_s = ST_RX_ARG;
               end else begin
                  state_nxt_s  = ST_TX_ERR;
                  ser_load_s   = 1'b1;
                  ser_single_s = 1'b1;
                  ser_status_s = RSP_BAD_HDR;
               end
            end else begin
               state_nxt_s = ST_RX_HDR;
            end
         end
         ST_RX_ARG: begin
            // An accepted byte wins over a simultaneous expiry
            if (rx_fire_s) begin
               state_nxt_s = (byte_idx_r == 2'd3) ? ST_ISSUE : ST_RX_ARG;
            end else if (timeout_hit_s) begin
               state_nxt_s  = ST_TX_ERR;
               ser_load_s   = 1'b1;
               ser_single_s = 1'b1;
               ser_status_s = RSP_TIMEOUT;
            end else begin
               state_nxt_s = ST_RX_ARG;
            end
         end
         ST_ISSUE: begin
            state_nxt_s = cmd_ready ? ST_WAIT_LOW : ST_ISSUE;
         end
         ST_WAIT_LOW: begin
            state_nxt_s = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (cmd_ready) begin
               state_nxt_s  = ST_TX_STATUS;
               ser_load_s   = 1'b1;
               ser_status_s = RSP_OK;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         ST_TX_STATUS: begin
            state_nxt_s = tx_fire_s ? ST_TX_RES : ST_TX_STATUS;
         end
         ST_TX_RES: begin
            state_nxt_s = (tx_fire_s && ser_last_s) ? ST_RX_HDR : ST_TX_RES;
         end
         ST_TX_ERR: begin
            state_nxt_s = tx_fire_s ? ST_RX_HDR : ST_TX_ERR;
         end
         default: begin
            state_nxt_s = ST_RX_HDR;
         end
      endcase
   end

   // State, opcode/argument capture and inter-byte timeout counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_RX_HDR;
         cmd_r      <= 3'd0;
         arg_r      <= 32'h0000_0000;
         byte_idx_r <= 2'd0;
         to_cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_RX_HDR) && rx_fire_s && hdr_ok(rx_data)) begin
            cmd_r      <= rx_data[2:0];
            byte_idx_r <= 2'd0;
         end else if ((state_r == ST_RX_ARG) && rx_fire_s) begin
            arg_r      <= {arg_r[23:0], rx_data};
            byte_idx_r <= byte_idx_r + 2'd1;
         end else begin
            cmd_r      <= cmd_r;
            byte_idx_r <= byte_idx_r;
         end
         if ((state_r == ST_RX_ARG) && !rx_fire_s && !timeout_hit_s) begin
            to_cnt_r <= to_cnt_r + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            to_cnt_r <= '0;
         end
      end
   end

   cmd_res_serializer u_ser (
      .clk         (clk),
      .reset       (reset),
      .load        (ser_load_s),
      .load_single (ser_single_s),
      .load_status (ser_status_s),
      .load_res    (cmd_res),
      .advance     (tx_fire_s),
      .tx_data     (tx_data),
      .last        (ser_last_s)
   );

endmodule
